sfx_sequencer: RTL and testbench

Sound-effect sequencer for the chess game's single PWM audio pin. Accepts one-cycle `play_sound`/`sound_code` requests from the game logic. Arbitrates each request against the effect already playing, then steps a fixed note ROM for the winning effect. Drives a half-period tone generator that toggles `pwm`. Sits between `Play` and the board's audio output, on the 100 MHz `clk` domain.

---
 rtl/sfx_pkg.sv | 57 +++++
 rtl/sfx_sequencer_tone_gen.sv | 27 ++
 rtl/sfx_sequencer.sv | 122 ++++++++++++
 tb/tb_sfx_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// Shared definitions for the sound-effect sequencer: effect codes, FSM states,
// the note-step record and the fixed note ROM.
package sfx_pkg;

  localparam logic [2:0] SFX_STOP    = 3'd0;
  localparam logic [2:0] SFX_CLICK   = 3'd1;
  localparam logic [2:0] SFX_PLACE   = 3'd2;
  localparam logic [2:0] SFX_INVALID = 3'd3;
  localparam logic [2:0] SFX_WIN     = 3'd4;

  // Width the ROM half-periods are stored at; the top resizes to its HP_W.
  localparam int SFX_ROM_HP_W = 18;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY
  } sfx_state_e;

  typedef struct packed {
    logic [SFX_ROM_HP_W-1:0] half_period;  // 0 = rest
    logic [7:0]              dur;          // duration in ticks
    logic                    last;
  } sfx_step_t;

  function automatic sfx_step_t sfx_rom(input logic [2:0] code, input logic [1:0] idx);
    sfx_step_t s;
    s = '{half_period: '0, dur: 8'd1, last: 1'b1};
    case (code)
      SFX_CLICK: s = '{18'd50000, 8'd20, 1'b1};
      SFX_PLACE: begin
        case (idx)
          2'd0:    s = '{18'd40000, 8'd30, 1'b0};
          default: s = '{18'd30000, 8'd30, 1'b1};
        endcase
      end
      SFX_INVALID: begin
        case (idx)
          2'd0:    s = '{18'd100000, 8'd60, 1'b0};
          2'd1:    s = '{18'd0,      8'd20, 1'b0};
          default: s = '{18'd100000, 8'd60, 1'b1};
        endcase
      end
      SFX_WIN: begin
        case (idx)
          2'd0:    s = '{18'd47778, 8'd100, 1'b0};
          2'd1:    s = '{18'd37921, 8'd100, 1'b0};
          2'd2:    s = '{18'd31888, 8'd100, 1'b0};
          default: s = '{18'd23889, 8'd200, 1'b1};
        endcase
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sfx_sequencer_tone_gen.sv
// Half-period square-wave generator: toggles pwm every half_period cycles,
// held low while cleared or when half_period is 0 (rest).
module tone_gen #(
  parameter int HP_W = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [HP_W-1:0] half_period,
  output logic            pwm
);

  logic [HP_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear || half_period == '0) begin
      cnt_q <= '0;
      pwm   <= 1'b0;
    end else if (cnt_q == half_period - HP_W'(1)) begin
      cnt_q <= '0;
      pwm   <= ~pwm;
    end else begin
      cnt_q <= cnt_q + HP_W'(1);
    end
  end

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: arbitrates play requests and steps the note ROM into
// tone_gen. Define SFX_PREEMPT_EN to let equal/higher codes preempt playback.
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int HP_W     = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play_sound,
  input  logic [2:0] sound_code,
  output logic       pwm,
  output logic       busy,
  output logic [2:0] cur_code,
  output logic       done
);

  localparam int             TW        = $clog2(TICK_DIV + 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);

  sfx_state_e    state_q, state_d;
  logic [2:0]    code_q, code_d;
  logic [1:0]    idx_q, idx_d;
  logic          done_q, done_d;
  sfx_step_t     step_q;
  logic [TW-1:0] tick_q;
  logic [7:0]    dur_q;

  logic req_ok, req_stop, req_start, preempt_ok;
  logic step_end, seq_end, tone_clear;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    req_ok   = play_sound && (sound_code <= SFX_WIN);
    step_end = (state_q == S_PLAY) && (tick_q == TICK_LAST) && (dur_q == step_q.dur - 8'd1);
    seq_end  = step_end && step_q.last;
`ifdef SFX_PREEMPT_EN
    preempt_ok = (sound_code >= code_q);
`else
    preempt_ok = 1'b0;
`endif
    req_stop  = req_ok && (sound_code == SFX_STOP);
    // A request landing on the final expiry wins over the natural finish.
    req_start = req_ok && (sound_code != SFX_STOP) &&
                ((state_q == S_IDLE) || seq_end || preempt_ok);
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    if (req_stop) begin
      state_d = S_IDLE;
      code_d  = SFX_STOP;
    end else if (req_start) begin
      state_d = S_LOAD;
      code_d  = sound_code;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_LOAD: state_d = S_PLAY;
        S_PLAY: begin
          if (seq_end) begin
            state_d = S_IDLE;
            code_d  = SFX_STOP;
            done_d  = 1'b1;
          end else if (step_end) begin
            state_d = S_LOAD;
            idx_d   = idx_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Counters and tone only run across edges that stay inside one PLAY step.
  assign tone_clear = !((state_q == S_PLAY) && (state_d == S_PLAY));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= SFX_STOP;
      idx_q   <= '0;
      done_q  <= 1'b0;
      step_q  <= '0;
      tick_q  <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      if (state_q == S_LOAD) step_q <= sfx_rom(code_q, idx_q);
      if (tone_clear) begin
        tick_q <= '0;
        dur_q  <= '0;
      end else if (tick_q == TICK_LAST) begin
        tick_q <= '0;
        dur_q  <= dur_q + 8'd1;
      end else begin
        tick_q <= tick_q + TW'(1);
      end
    end
  end

  tone_gen #(.HP_W(HP_W)) u_tone (
    .clk         (clk),
    .rst         (rst),
    .clear       (tone_clear),
    .half_period (HP_W'(step_q.half_period)),
    .pwm         (pwm)
  );

  assign busy     = (state_q != S_IDLE);
  assign cur_code = code_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Self-checking bench for sfx_sequencer: a timeline model of each effect predicts
// busy/cur_code/done/pwm every cycle; a slow-tick instance checks a real pwm edge.
module tb_sfx_sequencer;

  localparam int TD  = 10;
  localparam int TD2 = 2600;
`ifdef SFX_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, play_sound;
  logic [2:0] sound_code;
  logic       pwm, busy, done;
  logic [2:0] cur_code;
  logic       rst2, play2;
  logic [2:0] code2;
  logic       pwm2, busy2, done2;
  logic [2:0] cur2;

  always #5 clk = ~clk;

  sfx_sequencer #(.TICK_DIV(TD), .HP_W(18)) dut (
    .clk(clk), .rst(rst), .play_sound(play_sound), .sound_code(sound_code),
    .pwm(pwm), .busy(busy), .cur_code(cur_code), .done(done)
  );

  sfx_sequencer #(.TICK_DIV(TD2), .HP_W(18)) dut_long (
    .clk(clk), .rst(rst2), .play_sound(play2), .sound_code(code2),
    .pwm(pwm2), .busy(busy2), .cur_code(cur2), .done(done2)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int s2       = 0;
  string scen  = "init";

  always @(posedge clk) cyc <= cyc + 1;

  // Effect table as (half_period, dur ticks) per code.
  int n_steps [5]    = '{0, 1, 2, 3, 4};
  int hp_tab  [5][4] = '{'{0, 0, 0, 0}, '{50000, 0, 0, 0}, '{40000, 30000, 0, 0},
                         '{100000, 0, 100000, 0}, '{47778, 37921, 31888, 23889}};
  int dur_tab [5][4] = '{'{0, 0, 0, 0}, '{20, 0, 0, 0}, '{30, 30, 0, 0},
                         '{60, 20, 60, 0}, '{100, 100, 100, 200}};

  // Model: active code and cycles elapsed since the accepting edge (0 = LOAD).
  int   m_code = 0;
  int   m_k    = 0;
  logic m_done = 1'b0;

  function automatic int seq_len(input int c);
    int t = 0;
    for (int i = 0; i < n_steps[c]; i++) t += 1 + dur_tab[c][i] * TD;
    return t;
  endfunction

  function automatic logic pwm_at(input int c, input int k);
    int pos = 0;
    for (int i = 0; i < n_steps[c]; i++) begin
      int d = dur_tab[c][i] * TD;
      if (k > pos && k <= pos + d) begin
        int j = k - pos - 1;
        if (hp_tab[c][i] == 0) return 1'b0;
        return ((j / hp_tab[c][i]) % 2) == 1;
      end
      pos += 1 + d;
    end
    return 1'b0;
  endfunction

  task automatic model_edge(input logic r, input logic p, input logic [2:0] c);
    bit was_busy, last_exp, valid;
    m_done = 1'b0;
    if (r) begin
      m_code = 0;
      m_k    = 0;
    end else begin
      was_busy = (m_code != 0);
      last_exp = was_busy && (m_k == seq_len(m_code) - 1);
      valid    = p && (c <= 3'd4);
      if (valid && c == 3'd0) begin
        m_code = 0;
      end else if (valid && (!was_busy || last_exp || (PREEMPT && int'(c) >= m_code))) begin
        m_code = int'(c);
        m_k    = 0;
      end else if (was_busy) begin
        m_k++;
        if (m_k == seq_len(m_code)) begin
          m_done = 1'b1;
          m_code = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge pass, advance the model, compare all outputs.
  task automatic tick(input logic r, input logic p, input logic [2:0] c);
    rst = r; play_sound = p; sound_code = c;
    @(posedge clk);
    #1;
    model_edge(r, p, c);
    rst = 1'b0; play_sound = 1'b0; sound_code = 3'd0;
    check({scen, ".busy"},     32'(busy),     32'(m_code != 0));
    check({scen, ".cur_code"}, 32'(cur_code), 32'(m_code));
    check({scen, ".done"},     32'(done),     32'(m_done));
    check({scen, ".pwm"},      32'(pwm),      32'((m_code != 0) ? pwm_at(m_code, m_k) : 1'b0));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 3'd0);
  endtask

  task automatic run_to_idle(input int limit);
    int i = 0;
    while (m_code != 0 && i < limit) begin
      tick(1'b0, 1'b0, 3'd0);
      i++;
    end
    check({scen, ".finished"}, 32'(busy), 32'(0));
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; play_sound = 1'b0; sound_code = 3'd0;
    rst2 = 1'b1; play2 = 1'b0; code2 = 3'd0;

    scen = "reset";
    tick(1'b1, 1'b0, 3'd0);
    tick(1'b1, 1'b1, 3'd1);
    rst2 = 1'b0;
    tick(1'b0, 1'b0, 3'd0);

    play2 = 1'b1; code2 = 3'd1;
    tick(1'b0, 1'b0, 3'd0);
    play2 = 1'b0; code2 = 3'd0;
    s2 = cyc;

    scen = "reserved";
    tick(1'b0, 1'b1, 3'd6);
    tick(1'b0, 1'b1, 3'd7);
    tick(1'b0, 1'b0, 3'd3);
    run(3);

    scen = "click";
    tick(1'b0, 1'b1, 3'd1);
    run_to_idle(1000);
    run(2);

    scen = "place";
    tick(1'b0, 1'b1, 3'd2);
    run_to_idle(1000);
    run(2);

    scen = "invalid";
    tick(1'b0, 1'b1, 3'd3);
    run_to_idle(2000);
    run(2);

    scen = "preempt";
    tick(1'b0, 1'b1, 3'd1);
    run(50);
    tick(1'b0, 1'b1, 3'd4);
    run(100);
    tick(1'b0, 1'b1, 3'd2);
    run_to_idle(6000);
    run(2);

    scen = "stop";
    tick(1'b0, 1'b1, 3'd4);
    run(500);
    tick(1'b0, 1'b1, 3'd0);
    run(3);

    scen = "rst_mid";
    tick(1'b0, 1'b1, 3'd3);
    run(300);
    tick(1'b1, 1'b1, 3'd2);
    run(3);

    scen = "boundary";
    tick(1'b0, 1'b1, 3'd2);
    while (m_code == 2 && m_k < seq_len(2) - 1) tick(1'b0, 1'b0, 3'd0);
    tick(1'b0, 1'b1, 3'd1);
    run_to_idle(1000);
    run(2);

    scen = "random";
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 199);
      if (r < 6)       tick(1'b0, 1'b1, 3'($urandom_range(0, 7)));
      else if (r == 7) tick(1'b1, 1'b0, 3'd0);
      else             tick(1'b0, 1'b0, 3'($urandom_range(0, 7)));
    end
    run_to_idle(6000);

    scen = "long";
    check("long.schedule", 32'(cyc <= s2 + 50000), 32'(1));
    wait_cyc(s2 + 50000);
    check("long.pwm_before_rise", 32'(pwm2), 32'(0));
    check("long.busy",            32'(busy2), 32'(1));
    check("long.cur_code",        32'(cur2),  32'(1));
    wait_cyc(s2 + 50001);
    check("long.pwm_rise",        32'(pwm2), 32'(1));
    wait_cyc(s2 + 52000);
    check("long.busy_last",       32'(busy2), 32'(1));
    check("long.done_early",      32'(done2), 32'(0));
    check("long.pwm_last",        32'(pwm2),  32'(1));
    wait_cyc(s2 + 52001);
    check("long.busy_fall",       32'(busy2), 32'(0));
    check("long.done_pulse",      32'(done2), 32'(1));
    check("long.pwm_idle",        32'(pwm2),  32'(0));
    check("long.cur_idle",        32'(cur2),  32'(0));
    wait_cyc(s2 + 52002);
    check("long.done_single",     32'(done2), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
